program_loader: RTL

//  Boot-time writer for the multi-cycle computer's instruction memory; the write-side counterpart of the CPU fetch path.

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_word_packer.sv | 32 +++
 rtl/program_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// State encodings, header/word geometry and byte-counter width.
package program_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 8;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/program_loader_word_packer.sv
// Assembles little-endian bytes into one memory word.
// word_full flags that the next loaded byte completes the word.
module loader_word_packer
    import program_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        data,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    logic [CNT_W-1:0] count;

    // Shifting in from the top leaves byte 0 in word[7:0] after a full word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            word  <= '0;
        end else if (load) begin
            count <= count + 1'b1;
            word  <= {data, word[DATA_W-1:8]};
        end
    end

    assign word_full = (count == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: length header, then 64-bit words.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t FINISH = CHK;
`else
    localparam state_t FINISH = DONE;
`endif

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(2 ** ADDR_W);

    state_t           state;
    state_t           nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] hdr_len;
    logic             accept;
    logic             restart;
    logic             last_word;
    logic             word_full;

    assign accept    = in_valid && in_ready;
    assign restart   = reload && (state == DONE || state == ERROR);
    assign hdr_len   = {in_data, len[7:0]};
    assign last_word = ((LEN_W + 1)'(mem_addr) + (LEN_W + 1)'(1)) == {1'b0, len};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] xsum;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            xsum <= '0;
        end else if (accept && (state == LEN_LO || state == LEN_HI || state == DATA)) begin
            xsum <= xsum ^ in_data;
        end
    end
`endif

    always_comb begin
        nxt = state;
        case (state)
            LEN_LO: if (accept) nxt = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if ({1'b0, hdr_len} > MAX_LEN) nxt = ERROR;
                    else if (hdr_len == '0)        nxt = FINISH;
                    else                           nxt = DATA;
                end
            end
            DATA:   if (accept && word_full) nxt = WRITE;
            WRITE:  nxt = last_word ? FINISH : DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK:    if (accept) nxt = ((xsum ^ in_data) == '0) ? DONE : ERROR;
`endif
            DONE:   if (reload) nxt = LEN_LO;
            ERROR:  if (reload) nxt = LEN_LO;
            default: nxt = LEN_LO;
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LEN_LO;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            len       <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= nxt;
            in_ready  <= (nxt == LEN_LO || nxt == LEN_HI || nxt == DATA || nxt == CHK);
            mem_we    <= (nxt == WRITE);
            cpu_reset <= (nxt != DONE);
            done      <= (nxt == DONE);
            error     <= (nxt == ERROR);
            if (state == LEN_LO && accept) len[7:0]  <= in_data;
            if (state == LEN_HI && accept) len[15:8] <= in_data;
            // The final index is held so a full-size image never wraps the address.
            if (state == WRITE && !last_word) mem_addr <= mem_addr + 1'b1;
            if (restart) begin
                mem_addr <= '0;
                len      <= '0;
            end
        end
    end

    loader_word_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .load     (accept && state == DATA),
        .data     (in_data),
        .word     (mem_wdata),
        .word_full(word_full)
    );

endmodule
